// File: rtl/dual_arb_pkg.sv
// Shared types and defaults for the dual-channel round-robin arbiter.
package dual_arb_pkg;

   localparam int N_REQ_DEF    = 12;
   localparam int MAX_HOLD_DEF = 16;
   localparam int ID_W_MAX     = 4;   // enough for 16 requesters
   localparam int CNT_W        = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } ch_state_t;

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
      logic [CNT_W-1:0]    hold_cnt;
   } ch_t;

endpackage

// File: rtl/rr_dual_pick.sv
// Finds the first two set bits of eligible in circular order starting at ptr.
// Purely combinational: rotate so ptr sits at bit 0, scan upward, rotate indices back.
module rr_dual_pick #(
   parameter int N_REQ = 12,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [ID_W-1:0]  ptr,
   output logic             first_vld,
   output logic [ID_W-1:0]  first_idx,
   output logic             second_vld,
   output logic [ID_W-1:0]  second_idx
);

   localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

   logic [N_REQ-1:0] rot;
   logic [ID_W-1:0]  f_rot;
   logic [ID_W-1:0]  s_rot;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
      logic [ID_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= N_L) s = s - N_L;
      return s[ID_W-1:0];
   endfunction

   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = eligible[wrap_add(ID_W'(i), ptr)];
      end
   end

   always_comb begin
      first_vld  = 1'b0;
      second_vld = 1'b0;
      f_rot      = '0;
      s_rot      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (rot[i]) begin
            if (!first_vld) begin
               first_vld = 1'b1;
               f_rot     = ID_W'(i);
            end else if (!second_vld) begin
               second_vld = 1'b1;
               s_rot      = ID_W'(i);
            end
         end
      end
      first_idx  = wrap_add(f_rot, ptr);
      second_idx = wrap_add(s_rot, ptr);
   end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Round-robin arbiter granting two shared channels (A, B) to N_REQ level requesters.
// Grant and release take effect one edge after req changes; a grant held too long is revoked and masked.
module dual_grant_arbiter
   import dual_arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             a_valid,
   output logic [ID_W-1:0]  a_id,
   output logic             b_valid,
   output logic [ID_W-1:0]  b_id,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);
   localparam logic [ID_W:0]    N_L       = (ID_W+1)'(N_REQ);

   ch_state_t        st_q [2];
   ch_state_t        st_d [2];
   ch_t              ch_q [2];
   ch_t              ch_d [2];
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] mask_q, mask_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic             timeout_q, timeout_d;

   logic [N_REQ-1:0] eligible;
   logic             first_vld, second_vld;
   logic [ID_W-1:0]  first_idx, second_idx;
   logic [1:0]       drop, expire;
   logic             grant_a, grant_b, grant_two;
   logic [ID_W-1:0]  b_idx, last_idx;
   logic [ID_W:0]    ptr_nxt;

   assign eligible = req & ~gnt_q & ~mask_q;

   rr_dual_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .eligible   (eligible),
      .ptr        (ptr_q),
      .first_vld  (first_vld),
      .first_idx  (first_idx),
      .second_vld (second_vld),
      .second_idx (second_idx)
   );

   always_comb begin
      drop   = '0;
      expire = '0;
      for (int c = 0; c < 2; c++) begin
         if (st_q[c] == GRANT) begin
            if (!req[ch_q[c].id[ID_W-1:0]]) begin
               drop[c] = 1'b1;
            end else if (MAX_HOLD != 0 && ch_q[c].hold_cnt == HOLD_LAST) begin
               expire[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      // Allocation only sees channels idle before this edge, so a freed channel waits one cycle.
      grant_a   = first_vld && (st_q[0] == IDLE);
      grant_two = second_vld && (st_q[0] == IDLE) && (st_q[1] == IDLE);
      grant_b   = (first_vld && (st_q[0] == GRANT) && (st_q[1] == IDLE)) || grant_two;
      b_idx     = (st_q[0] == IDLE) ? second_idx : first_idx;

      for (int c = 0; c < 2; c++) begin
         st_d[c] = st_q[c];
         ch_d[c] = ch_q[c];
         if (st_q[c] == GRANT) begin
            if (drop[c] || expire[c]) begin
               st_d[c]       = IDLE;
               ch_d[c].valid = 1'b0;
            end else if (ch_q[c].hold_cnt != HOLD_LAST) begin
               ch_d[c].hold_cnt = ch_q[c].hold_cnt + CNT_W'(1);
            end
         end
      end

      if (grant_a) begin
         st_d[0] = GRANT;
         ch_d[0] = '{valid: 1'b1, id: ID_W_MAX'(first_idx), hold_cnt: '0};
      end
      if (grant_b) begin
         st_d[1] = GRANT;
         ch_d[1] = '{valid: 1'b1, id: ID_W_MAX'(b_idx), hold_cnt: '0};
      end

      last_idx = grant_two ? second_idx : first_idx;
      ptr_nxt  = {1'b0, last_idx} + (ID_W+1)'(1);
      if (ptr_nxt == N_L) ptr_nxt = '0;
      ptr_d = (grant_a || grant_b) ? ptr_nxt[ID_W-1:0] : ptr_q;

      mask_d = mask_q & req;
      for (int c = 0; c < 2; c++) begin
         if (expire[c]) mask_d[ch_q[c].id[ID_W-1:0]] = 1'b1;
      end
      timeout_d = |expire;

      gnt_d = '0;
      for (int c = 0; c < 2; c++) begin
         if (ch_d[c].valid) gnt_d[ch_d[c].id[ID_W-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= '{IDLE, IDLE};
         ch_q      <= '{default: '0};
         gnt_q     <= '0;
         mask_q    <= '0;
         ptr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         ch_q      <= ch_d;
         gnt_q     <= gnt_d;
         mask_q    <= mask_d;
         ptr_q     <= ptr_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign a_valid = ch_q[0].valid;
   assign a_id    = ch_q[0].id[ID_W-1:0];
   assign b_valid = ch_q[1].valid;
   assign b_id    = ch_q[1].id[ID_W-1:0];
   assign timeout = timeout_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Scoreboard bench: the driver queues the expected outputs for each edge, a monitor pops and compares.
module tb_dual_grant_arbiter;

   localparam int N  = 12;
   localparam int MH = 4;
   localparam int IW = 4;

   typedef struct {
      logic [N-1:0]  gnt;
      logic          av;
      logic [IW-1:0] aid;
      logic          bv;
      logic [IW-1:0] bid;
      logic          to;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          a_valid, b_valid, timeout;
   logic [IW-1:0] a_id, b_id;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   dual_grant_arbiter #(
      .N_REQ    (N),
      .MAX_HOLD (MH),
      .ID_W     (IW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .a_valid (a_valid),
      .a_id    (a_id),
      .b_valid (b_valid),
      .b_id    (b_id),
      .timeout (timeout)
   );

   // Apply one cycle of stimulus and queue what the outputs must be after the following edge.
   task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] g,
                        input logic av, input int aid, input logic bv, input int bid, input logic to);
      exp_t e;
      @(negedge clk);
      reset = rst;
      req   = r;
      e.gnt = g;
      e.av  = av;
      e.aid = IW'(aid);
      e.bv  = bv;
      e.bid = IW'(bid);
      e.to  = to;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (gnt === e.gnt && a_valid === e.av && a_id === e.aid && b_valid === e.bv &&
                b_id === e.bid && timeout === e.to) begin
               n_pass++;
            end else begin
               $display("FAIL chk%0d: got gnt=%h a=%b/%0d b=%b/%0d to=%b, want gnt=%h a=%b/%0d b=%b/%0d to=%b",
                        n_checks, gnt, a_valid, a_id, b_valid, b_id, timeout,
                        e.gnt, e.av, e.aid, e.bv, e.bid, e.to);
            end
         end
      end
   end

   initial begin : stim
      logic [N-1:0] one;
      logic [N-1:0] pair;
      int           p;
      one   = 12'd1;
      reset = 1'b1;
      req   = 12'hFFF;

      // reset with everyone requesting, then first allocation from ptr 0
      drive(1, 12'hFFF, 12'h000, 0, 0, 0, 0, 0);
      drive(1, 12'hFFF, 12'h000, 0, 0, 0, 0, 0);
      drive(0, 12'hFFF, 12'h003, 1, 0, 1, 1, 0);
      drive(0, 12'hFFC, 12'h000, 0, 0, 0, 1, 0);
      drive(0, 12'hFFC, 12'h00C, 1, 2, 1, 3, 0);

      // wraparound pair from ptr 0; ptr returns to 0
      drive(1, 12'h000, 12'h000, 0, 0, 0, 0, 0);
      drive(0, 12'h801, 12'h801, 1, 0, 1, 11, 0);
      drive(0, 12'h000, 12'h000, 0, 0, 0, 11, 0);
      drive(0, 12'h801, 12'h801, 1, 0, 1, 11, 0);
      drive(0, 12'h000, 12'h000, 0, 0, 0, 11, 0);

      // A owns 3, then 3 drops while 4,5 request: B takes 4 at once, A takes 5 one edge later
      drive(0, 12'h008, 12'h008, 1, 3, 0, 11, 0);
      drive(0, 12'h008, 12'h008, 1, 3, 0, 11, 0);
      drive(0, 12'h030, 12'h010, 0, 3, 1, 4, 0);
      drive(0, 12'h030, 12'h030, 1, 5, 1, 4, 0);
      drive(0, 12'h000, 12'h000, 0, 5, 0, 4, 0);

      // hold timeout on requester 2, masked until req goes low
      drive(0, 12'h004, 12'h004, 1, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h004, 1, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h004, 1, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h004, 1, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h000, 0, 2, 0, 4, 1);
      drive(0, 12'h004, 12'h000, 0, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h000, 0, 2, 0, 4, 0);
      drive(0, 12'h000, 12'h000, 0, 2, 0, 4, 0);
      drive(0, 12'h004, 12'h004, 1, 2, 0, 4, 0);
      drive(0, 12'h000, 12'h000, 0, 2, 0, 4, 0);

      // both channels time out on the same edge: one pulse, both masked
      drive(0, 12'h030, 12'h030, 1, 4, 1, 5, 0);
      drive(0, 12'h030, 12'h030, 1, 4, 1, 5, 0);
      drive(0, 12'h030, 12'h030, 1, 4, 1, 5, 0);
      drive(0, 12'h030, 12'h030, 1, 4, 1, 5, 0);
      drive(0, 12'h030, 12'h000, 0, 4, 0, 5, 1);
      drive(0, 12'h030, 12'h000, 0, 4, 0, 5, 0);
      drive(0, 12'h00C, 12'h00C, 1, 2, 1, 3, 0);
      drive(0, 12'h000, 12'h000, 0, 2, 0, 3, 0);

      // fairness: all request, each pair released after one cycle, ptr starts at 4
      for (int r = 0; r < 6; r++) begin
         p    = (4 + 2 * r) % N;
         pair = (one << p) | (one << (p + 1));
         drive(0, 12'hFFF, pair, 1, p, 1, p + 1, 0);
         drive(0, 12'hFFF & ~pair, 12'h000, 0, p, 0, p + 1, 0);
      end

      // reset while A=7, B=9 are busy; ptr must be back at 0 afterwards
      drive(0, 12'h280, 12'h280, 1, 7, 1, 9, 0);
      drive(0, 12'h280, 12'h280, 1, 7, 1, 9, 0);
      drive(1, 12'h280, 12'h000, 0, 0, 0, 0, 0);
      drive(0, 12'h801, 12'h801, 1, 0, 1, 11, 0);
      drive(0, 12'h000, 12'h000, 0, 0, 0, 11, 0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
